// File: rtl/conv7_filter_pkg.sv
// Shared constants, mode encodings and pipeline sideband for the 7x7 filter.
package conv7_pkg;

  localparam int unsigned PIX_W       = 10;
  localparam int unsigned K           = 7;
  localparam int unsigned PIX_MAX     = (32'd1 << PIX_W) - 32'd1;
  localparam int unsigned BINOM [K]   = '{1, 6, 15, 20, 15, 6, 1};
  localparam int unsigned BINOM_SHIFT = 12;
  localparam int unsigned GAUSS_ROUND = 32'd1 << (BINOM_SHIFT - 1);
  localparam int unsigned BOX_RECIP   = 1337;
  localparam int unsigned BOX_SHIFT   = 16;
  localparam int unsigned BOX_ROUND   = 32'd1 << (BOX_SHIFT - 1);

  localparam int unsigned WSUM_W = 17;
  localparam int unsigned PSUM_W = 13;
  localparam int unsigned G_W    = 23;
  localparam int unsigned S_W    = 16;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_BOX   = 2'b01,
    MODE_GAUSS = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  typedef struct packed {
    logic             valid;
    mode_e            mode;
    logic             border;
    logic [PIX_W-1:0] centre;
    logic             line_end;
    logic             frame_end;
  } sideband_t;

  function automatic logic [PIX_W-1:0] sat_pix(input int unsigned v);
    return (v > PIX_MAX) ? '1 : PIX_W'(v);
  endfunction

  function automatic logic [PIX_W-1:0] box_scale(input logic [S_W-1:0] s);
    return sat_pix((32'(s) * BOX_RECIP + BOX_ROUND) >> BOX_SHIFT);
  endfunction

  function automatic logic [PIX_W-1:0] gauss_scale(input logic [G_W-1:0] g);
    return sat_pix((32'(g) + GAUSS_ROUND) >> BINOM_SHIFT);
  endfunction

endpackage

// File: rtl/conv7_filter_row_sum.sv
// Combinational binomial-weighted sum and plain sum of one 7-pixel window row.
module conv7_row_sum
  import conv7_pkg::*;
(
  input  logic [K*PIX_W-1:0] row,
  output logic [WSUM_W-1:0]  wsum,
  output logic [PSUM_W-1:0]  psum
);

  always_comb begin
    wsum = '0;
    psum = '0;
    for (int unsigned c = 0; c < K; c++) begin
      wsum = wsum + WSUM_W'(BINOM[c]) * WSUM_W'(row[c*PIX_W +: PIX_W]);
      psum = psum + PSUM_W'(row[c*PIX_W +: PIX_W]);
    end
  end

endmodule

// File: rtl/conv7_filter.sv
// 3-stage 7x7 filter (passthrough / box mean / binomial Gaussian) with raster
// position tracking, border blanking and line/frame end flags.
module conv7_filter #(
  parameter int PIX_W = 10,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [49*PIX_W-1:0]  window,
  input  logic                 win_valid,
  input  logic                 frame_start,
  input  logic [1:0]           mode,
  output logic [PIX_W-1:0]     pix_out,
  output logic                 pix_valid,
  output logic                 line_end,
  output logic                 frame_end
);
  import conv7_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic          last_col, last_row;

  // frame_start overrides the running position for this window only
  always_comb begin
    cur_col  = frame_start ? '0 : col;
    cur_row  = frame_start ? '0 : row;
    last_col = (cur_col == CW'(IMG_W - 1));
    last_row = (cur_row == RW'(IMG_H - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (win_valid) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  sideband_t sb_in, sb1, sb2;

  always_comb begin
    sb_in           = '0;
    sb_in.valid     = win_valid;
    sb_in.mode      = mode_e'(mode);
    sb_in.border    = (32'(cur_col) < K - 1) || (32'(cur_row) < K - 1);
    sb_in.centre    = window[24*PIX_W +: PIX_W];
    sb_in.line_end  = last_col;
    sb_in.frame_end = last_col && last_row;
  end

  logic [WSUM_W-1:0] gs_c [K];
  logic [PSUM_W-1:0] bs_c [K];
  logic [WSUM_W-1:0] gs1  [K];
  logic [PSUM_W-1:0] bs1  [K];

  for (genvar g = 0; g < K; g++) begin : g_rows
    conv7_row_sum u_row_sum (
      .row  (window[(K-1-g)*K*PIX_W +: K*PIX_W]),
      .wsum (gs_c[g]),
      .psum (bs_c[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb1 <= '0;
      gs1 <= '{default: '0};
      bs1 <= '{default: '0};
    end else begin
      sb1 <= sb_in;
      gs1 <= gs_c;
      bs1 <= bs_c;
    end
  end

  logic [G_W-1:0] g_sum, g2;
  logic [S_W-1:0] s_sum, s2;

  always_comb begin
    g_sum = '0;
    s_sum = '0;
    for (int unsigned r = 0; r < K; r++) begin
      g_sum = g_sum + G_W'(BINOM[r]) * G_W'(gs1[r]);
      s_sum = s_sum + S_W'(bs1[r]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb2 <= '0;
      g2  <= '0;
      s2  <= '0;
    end else begin
      sb2 <= sb1;
      g2  <= g_sum;
      s2  <= s_sum;
    end
  end

  logic [PIX_W-1:0] result;

  always_comb begin
    result = sb2.centre;
    case (sb2.mode)
      MODE_BOX:   result = sb2.border ? '0 : box_scale(s2);
      MODE_GAUSS: result = sb2.border ? '0 : gauss_scale(g2);
      default:    result = sb2.centre;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_out   <= '0;
      pix_valid <= 1'b0;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      pix_valid <= sb2.valid;
      line_end  <= sb2.valid & sb2.line_end;
      frame_end <= sb2.valid & sb2.frame_end;
      if (sb2.valid) pix_out <= result;
    end
  end

endmodule

// File: tb/tb_conv7_filter.sv
// Scoreboard bench for conv7_filter on a 16x8 raster with random windows.
module tb_conv7_filter;

  localparam int TW = 16;
  localparam int TH = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [489:0] window = '0;
  logic         win_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [9:0]   pix_out;
  logic         pix_valid, line_end, frame_end;

  conv7_filter #(.PIX_W(10), .IMG_W(TW), .IMG_H(TH)) dut (
    .clk         (clk),
    .reset       (reset),
    .window      (window),
    .win_valid   (win_valid),
    .frame_start (frame_start),
    .mode        (mode),
    .pix_out     (pix_out),
    .pix_valid   (pix_valid),
    .line_end    (line_end),
    .frame_end   (frame_end)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     pix;
    bit     le;
    bit     fe;
    longint due;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   pix[7][7];
  int   wt[7] = '{1, 6, 15, 20, 15, 6, 1};
  int   m_col = 0, m_row = 0;
  int   n_pv = 0, n_le = 0, n_fe = 0;

  // Reference: filter the 7x7 array directly from the weight rules
  function automatic int model(int md, bit border);
    int s = 0;
    int g = 0;
    int v;
    if ((md == 1 || md == 2) && border) return 0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) begin
        s += pix[r][c];
        g += wt[r] * wt[c] * pix[r][c];
      end
    if (md == 1) v = (s * 1337 + 32768) / 65536;
    else if (md == 2) v = (g + 2048) / 4096;
    else v = pix[3][3];
    return (v > 1023) ? 1023 : v;
  endfunction

  task automatic fill(input int kind);
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        case (kind)
          0: pix[r][c] = int'($urandom_range(0, 1023));
          1: pix[r][c] = 512;
          2: pix[r][c] = 1023;
          default: pix[r][c] = (r == 3 && c == 3) ? 1023 : 0;
        endcase
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        window[(6-r)*70 + c*10 +: 10] = 10'(pix[r][c]);
  endtask

  // Called at posedge+1; leaves the bench at the next posedge+1
  task automatic send(input int kind, input int md, input bit fs);
    int   pc, pr;
    bit   border;
    exp_t x;
    fill(kind);
    win_valid   = 1'b1;
    frame_start = fs;
    mode        = 2'(md);
    pc = fs ? 0 : m_col;
    pr = fs ? 0 : m_row;
    border = (pc < 6) || (pr < 6);
    x.pix = model(md, border);
    x.le  = (pc == TW - 1);
    x.fe  = (pc == TW - 1) && (pr == TH - 1);
    x.due = cyc + 3;
    sbq.push_back(x);
    if (pc == TW - 1) begin
      m_col = 0;
      m_row = (pr == TH - 1) ? 0 : pr + 1;
    end else begin
      m_col = pc + 1;
      m_row = pr;
    end
    @(posedge clk);
    #1;
    win_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic maybe_gap();
    if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  // Monitor: pops one expectation per presented output
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (sbq.size() > 0 && sbq[0].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_output due=%0d now=%0d", sbq[0].due, cyc);
        void'(sbq.pop_front());
      end
      if (pix_valid) begin
        n_pv++;
        if (line_end) n_le++;
        if (frame_end) n_fe++;
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output got pix=%0d le=%0b fe=%0b", pix_out, line_end, frame_end);
        end else begin
          e = sbq.pop_front();
          if (pix_out !== 10'(e.pix) || line_end !== e.le || frame_end !== e.fe || cyc != e.due) begin
            failures++;
            $display("FAIL output got pix=%0d le=%0b fe=%0b cyc=%0d required pix=%0d le=%0b fe=%0b cyc=%0d",
                     pix_out, line_end, frame_end, cyc, e.pix, e.le, e.fe, e.due);
          end
        end
      end else if (line_end || frame_end) begin
        checks++;
        failures++;
        $display("FAIL flag_without_valid got le=%0b fe=%0b required 0 0", line_end, frame_end);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_int("reset_pix_valid", int'(pix_valid), 0);
    check_int("reset_pix_out", int'(pix_out), 0);
    check_int("reset_flags", int'({line_end, frame_end}), 0);

    // Frame 1: Gaussian, random patterns and gaps, frame_start on first window
    n_pv = 0; n_le = 0; n_fe = 0;
    for (int i = 0; i < TW * TH; i++) begin
      send(int'($urandom_range(0, 3)), 2, i == 0);
      maybe_gap();
    end
    drain();
    check_int("frame1_outputs", n_pv, TW * TH);
    check_int("frame1_line_ends", n_le, TH);
    check_int("frame1_frame_ends", n_fe, 1);

    // Frame 2: random modes, natural wrap, frame_start coinciding with a line wrap
    for (int i = 0; i < TW * TH; i++) begin
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           (m_col == TW - 1) && (m_row == 3));
      maybe_gap();
    end
    drain();

    // Frame 3: impulse back-to-back, mode toggling Gaussian/box every cycle
    for (int i = 0; i < TW * TH; i++)
      send(3, (i % 2 == 0) ? 2 : 1, i == 0);
    drain();

    // Reset mid-stream with results in flight
    for (int i = 0; i < 4; i++) send(1, 0, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    check_int("async_reset_pix_valid", int'(pix_valid), 0);
    check_int("async_reset_pix_out", int'(pix_out), 0);
    sbq.delete();
    m_col = 0;
    m_row = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(6);
    n_pv = 0;
    for (int i = 0; i < TW * TH; i++) begin
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
      maybe_gap();
    end
    drain();
    check_int("post_reset_outputs", n_pv, TW * TH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
